// File: rtl/gauss_pkg.sv
// Shared defaults and FSM state encoding for the Gaussian filter front end.
package gauss_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } lb_state_e;

endpackage

// File: rtl/line_ram.sv
// Single-port row store with a registered, read-before-write read port.
module line_ram #(
  parameter  int DEPTH  = 640,
  parameter  int DATA_W = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array kept out of the reset block so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     rdata_q <= '0;
    else if (i_en) rdata_q <= mem[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer producing vertical pixel columns for the 3x3 Gaussian window.
// Optional top-border replication via LINE_BUFFER_3ROW_BORDER_REPLICATE_EN.
module line_buffer_3row
  import gauss_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_data,
  output logic [3*DATA_W-1:0] o_col,
  output logic                o_col_valid,
  output logic                o_sol,
  output logic                o_eol,
  output logic                o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  lb_state_e     state_q, state_d;
  logic          old_q, old_d;   // which RAM holds row n-2 (overwritten this row)

  logic              acc, col_last, row_last;
  logic [DATA_W-1:0] pix_q, rd_a, rd_b, top, mid;
  logic              sel_q, vld_q, sol_q, eol_q, done_q;

  assign acc      = i_valid & ~i_rst;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    old_d   = old_q;
    if (acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
        old_d = ~old_q;
        case (state_q)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = RUN;
          RUN:     state_d = row_last ? FILL0 : RUN;
          default: state_d = FILL0;
        endcase
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // The two RAMs swap roles each row instead of copying row n-1 into row n-2:
  // only the RAM holding row n-2 is written, and its old value is read first.
  line_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_ram_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (acc),
    .i_we    (~old_q),
    .i_addr  (col_q),
    .i_wdata (i_data),
    .o_rdata (rd_a)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_ram_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (acc),
    .i_we    (old_q),
    .i_addr  (col_q),
    .i_wdata (i_data),
    .o_rdata (rd_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL0;
      old_q   <= 1'b0;
      pix_q   <= '0;
      sel_q   <= 1'b0;
      vld_q   <= 1'b0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      old_q   <= old_d;
`ifdef LINE_BUFFER_3ROW_BORDER_REPLICATE_EN
      vld_q   <= acc;
`else
      vld_q   <= acc && (state_q == RUN);
`endif
      sol_q   <= acc && (col_q == '0);
      eol_q   <= acc && col_last;
      done_q  <= acc && col_last && row_last;
      if (acc) begin
        pix_q <= i_data;
        sel_q <= old_q;
      end
    end
  end

  assign top = sel_q ? rd_b : rd_a;
  assign mid = sel_q ? rd_a : rd_b;

`ifdef LINE_BUFFER_3ROW_BORDER_REPLICATE_EN
  logic fill0_q, fill1_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill0_q <= 1'b0;
      fill1_q <= 1'b0;
    end else if (acc) begin
      fill0_q <= (state_q == FILL0);
      fill1_q <= (state_q == FILL1);
    end
  end

  always_comb begin
    o_col = {top, mid, pix_q};
    if (fill0_q)      o_col = {pix_q, pix_q, pix_q};
    else if (fill1_q) o_col = {mid, mid, pix_q};
  end
`else
  assign o_col = {top, mid, pix_q};
`endif

  assign o_col_valid  = vld_q;
  assign o_sol        = sol_q;
  assign o_eol        = eol_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row on a 4x4 image, pixel = base + 16*row + col.
module tb_line_buffer_3row;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
`ifdef LINE_BUFFER_3ROW_BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam int PER_FRAME = BORDER ? W*H : W*(H-2);

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic [DW-1:0]   i_data;
  logic [3*DW-1:0] o_col;
  logic            o_col_valid, o_sol, o_eol, o_frame_done;

  line_buffer_3row #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_col        (o_col),
    .o_col_valid  (o_col_valid),
    .o_sol        (o_sol),
    .o_eol        (o_eol),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3*DW-1:0] col;
    logic            sol;
    logic            eol;
    logic            done;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   vld_cnt = 0, done_cnt = 0;
  bit   in_vld_prev = 1'b0;

  // Output monitor: every valid column must follow an accepted pixel and match the queue head.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_col_valid) begin
      vld_cnt++;
      checks++;
      if (!in_vld_prev) begin
        errors++;
        $display("FAIL valid_after_idle: o_col_valid=1 with no pixel accepted on the previous edge");
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_col: got col=%h sol=%b eol=%b done=%b, none expected",
                 o_col, o_sol, o_eol, o_frame_done);
      end else begin
        e = q.pop_front();
        if ({o_col, o_sol, o_eol, o_frame_done} !== {e.col, e.sol, e.eol, e.done}) begin
          errors++;
          $display("FAIL column: got col=%h sol=%b eol=%b done=%b, want col=%h sol=%b eol=%b done=%b",
                   o_col, o_sol, o_eol, o_frame_done, e.col, e.sol, e.eol, e.done);
        end
      end
    end else if (o_frame_done) begin
      checks++;
      errors++;
      $display("FAIL done_without_col: o_frame_done=1 while o_col_valid=0");
    end
    if (o_frame_done) done_cnt++;
    in_vld_prev = i_valid && !i_rst;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit push, input exp_t e);
    i_valid = 1'b1;
    i_data  = d;
    if (push) q.push_back(e);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] base, input bit toggle, input int npix);
    for (int k = 0; k < npix; k++) begin
      int r, c;
      logic [DW-1:0] top, mid, bot;
      exp_t e;
      r   = k / W;
      c   = k % W;
      bot = base + DW'(16*r + c);
      if (r >= 2) begin
        top = base + DW'(16*(r-2) + c);
        mid = base + DW'(16*(r-1) + c);
      end else if (r == 1) begin
        top = base + DW'(c);
        mid = base + DW'(c);
      end else begin
        top = bot;
        mid = bot;
      end
      e.col  = {top, mid, bot};
      e.sol  = (c == 0);
      e.eol  = (c == W-1);
      e.done = (r == H-1) && (c == W-1);
      send(bot, (r >= 2) || BORDER, e);
      if (toggle) idle(1);
    end
  endtask

  task automatic drain_check(input string name, input int exp_vld, input int exp_done);
    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d expected columns never produced, want 0", name, q.size());
      q.delete();
    end
    checks++;
    if (vld_cnt != exp_vld) begin
      errors++;
      $display("FAIL %s_col_count: got %0d, want %0d", name, vld_cnt, exp_vld);
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL %s_frame_done_count: got %0d, want %0d", name, done_cnt, exp_done);
    end
    vld_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    idle(2);
    @(negedge i_clk);
    checks++;
    if (o_col !== '0) begin
      errors++;
      $display("FAIL reset_col: got %h, want 0", o_col);
    end
    checks++;
    if ({o_col_valid, o_sol, o_eol, o_frame_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got vld/sol/eol/done=%b, want 0000",
               {o_col_valid, o_sol, o_eol, o_frame_done});
    end
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_col_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid: cycle %0d got o_col_valid=%b, want 0", i, o_col_valid);
      end
    end
    @(posedge i_clk);
    #1;
    vld_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic test_frame();
    run_frame(8'h00, 1'b0, W*H);
    drain_check("frame", PER_FRAME, 1);
  endtask

  task automatic test_toggle();
    run_frame(8'h00, 1'b1, W*H);
    drain_check("toggle", PER_FRAME, 1);
  endtask

  task automatic test_reset_mid();
    // Aborted frame uses a different base so stale rows would be visible.
    run_frame(8'h80, 1'b0, 2*W + 1);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'hEE;
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_col_valid, o_col} !== {1'b0, {3*DW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid_outputs: got vld=%b col=%h, want vld=0 col=0", o_col_valid, o_col);
    end
    @(posedge i_clk);
    #1;
    run_frame(8'h00, 1'b0, W*H);
    drain_check("reset_mid", PER_FRAME + (BORDER ? 2*W + 1 : 1), 1);
  endtask

  task automatic test_back_to_back();
    run_frame(8'h00, 1'b0, W*H);
    run_frame(8'h40, 1'b0, W*H);
    drain_check("back_to_back", 2*PER_FRAME, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    test_reset();
    test_frame();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
